// File: rtl/analyzer_fifo_drain.sv
// Analyzer sample FIFO read-side drain engine.
// Streams a counted block of FIFO words to the upload path.
module analyzer_fifo_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  sample_count,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_BMAX =
    CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] LP_ONE =
    CNT_WIDTH'(1);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CNT_WIDTH-1:0]           r_rd_left;
  logic [CNT_WIDTH-1:0]           r_tx_left;
  logic [CNT_WIDTH-1:0]           r_burst_idx;
  logic                           r_inflight;
  logic [1:0][DATA_WIDTH-1:0]     r_buf;
  logic                           r_rd_ptr;
  logic                           r_wr_ptr;
  logic [1:0]                     r_occ;

  logic                           w_accept;
  logic                           w_head_vld;
  logic [DATA_WIDTH-1:0]          w_head_data;
  logic                           w_hs;
  logic                           w_pop;
  logic                           w_push;
  logic                           w_final;
  logic                           w_room;
  logic                           w_rd_en;

  assign w_accept = (r_state == S_IDLE)
                  & start & !abort;

  // An empty buffer lets the returning word
  // bypass straight to the stream port.
  assign w_head_vld  = (r_occ != 2'd0) | r_inflight;
  assign w_head_data = (r_occ != 2'd0)
                     ? r_buf[r_rd_ptr]
                     : fifo_rd_data;

  assign w_hs    = w_head_vld & m_ready;
  assign w_pop   = w_hs & (r_occ != 2'd0);
  assign w_push  = r_inflight
                 & !(w_hs & (r_occ == 2'd0));
  assign w_final = w_hs & (r_tx_left == LP_ONE);

  assign w_room = ({1'b0, r_occ}
                 + {2'b00, r_inflight}) < 3'd2;

  assign w_rd_en = (r_state == S_DRAIN)
                 & !fifo_rd_empty
                 & (r_rd_left != '0)
                 & w_room
                 & !abort;

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = w_head_vld;
  assign m_data     = w_head_vld ? w_head_data
                                 : '0;
  assign m_last     = w_head_vld
                    & ((r_burst_idx == LP_BMAX)
                     | (r_tx_left == LP_ONE));
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (sample_count == '0)
            w_state_nxt = S_DONE;
          else
            w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_final)
          w_state_nxt = S_DONE;
        else if (r_rd_left == '0)
          w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_final)
          w_state_nxt = S_DONE;
        else if (!w_head_vld
                 && r_tx_left == '0)
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_left   <= '0;
      r_tx_left   <= '0;
      r_burst_idx <= '0;
    end else if (abort) begin
      r_rd_left   <= '0;
      r_tx_left   <= '0;
      r_burst_idx <= '0;
    end else if (w_accept) begin
      r_rd_left   <= sample_count;
      r_tx_left   <= sample_count;
      r_burst_idx <= '0;
    end else begin
      if (w_rd_en)
        r_rd_left <= r_rd_left - LP_ONE;
      if (w_hs) begin
        r_tx_left <= r_tx_left - LP_ONE;
        if (r_burst_idx == LP_BMAX)
          r_burst_idx <= '0;
        else
          r_burst_idx <= r_burst_idx + LP_ONE;
      end
    end
  end

  // Two-entry skid buffer; abort drops both
  // the stored words and any read in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_buf      <= '0;
    end else if (abort) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_push) begin
        r_buf[r_wr_ptr] <= fifo_rd_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      unique case (1'b1)
        (w_push & !w_pop): r_occ <= r_occ + 2'd1;
        (w_pop & !w_push): r_occ <= r_occ - 2'd1;
        default:           r_occ <= r_occ;
      endcase
    end
  end

endmodule
